// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline-stage register with a two-entry skid buffer, flush,
// bubble control masking and a saturating stall counter.
module pipe_stage_skid #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              flush,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              r_main_valid;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic              r_skid_valid;
   logic [DATA_W-1:0] r_skid_data;
   logic [CTRL_W-1:0] r_skid_ctrl;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic w_in_fire;
   logic w_out_fire;
   logic w_stall;

   // in_ready depends only on a register, so out_ready never reaches it combinationally
   assign in_ready   = !r_skid_valid;
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = r_main_valid & out_ready;
   assign w_stall    = r_main_valid & !out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main_data  <= '0;
         r_main_ctrl  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_ctrl  <= '0;
      end else if (flush) begin
         // Any beat accepted this cycle is swallowed; data fields keep their values
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
         if (w_out_fire) begin
            r_main_data  <= r_skid_data;
            r_main_ctrl  <= r_skid_ctrl;
            r_skid_valid <= 1'b0;
         end
      end else if (w_in_fire) begin
         if (!r_main_valid || w_out_fire) begin
            r_main_valid <= 1'b1;
            r_main_data  <= in_data;
            r_main_ctrl  <= in_ctrl;
         end else begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= in_data;
            r_skid_ctrl  <= in_ctrl;
         end
      end else if (w_out_fire) begin
         r_main_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (w_stall && !flush && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign out_valid = r_main_valid;
   assign out_data  = r_main_data;
   assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush,
// bubble masking and stall-counter saturation with hand-computed expectations.
module tb_pipe_stage_skid;

   localparam int DATA_W = 32;
   localparam int CTRL_W = 16;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              flush;
   logic              cnt_clr;
   logic [CNT_W-1:0]  stall_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .flush     (flush),
      .cnt_clr   (cnt_clr),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      cnt_clr   = 1'b0;
      tick();
      tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_ready", 64'(in_ready), 64'd1);
      check("rst_cnt",   64'(stall_cnt), 64'd0);
      rst_n = 1'b1;
      tick();

      // Streaming 0..9
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 32'(i);
         in_ctrl = 16'(i + 1);
         check("strm_rdy", 64'(in_ready), 64'd1);
         tick();
         check("strm_vld",  64'(out_valid), 64'd1);
         check("strm_data", 64'(out_data), 64'(i));
         check("strm_ctrl", 64'(out_ctrl), 64'(i + 1));
      end
      in_valid = 1'b0;
      tick();
      check("strm_end_vld",  64'(out_valid), 64'd0);
      check("strm_end_ctrl", 64'(out_ctrl), 64'd0);
      check("strm_cnt",      64'(stall_cnt), 64'd0);

      // Backpressure A,B,C,D
      in_valid = 1'b1; in_data = 32'hA; in_ctrl = 16'h00A;
      tick();
      check("bp_a", 64'(out_data), 64'hA);
      out_ready = 1'b0;
      in_data = 32'hB; in_ctrl = 16'h00B;
      tick();
      in_data = 32'hC; in_ctrl = 16'h00C;
      check("bp_rdy_drop", 64'(in_ready), 64'd0);
      check("bp_hold_a",   64'(out_data), 64'hA);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_rdy_low", 64'(in_ready), 64'd0);
         check("bp_stable",  64'(out_data), 64'hA);
         check("bp_vld",     64'(out_valid), 64'd1);
      end
      check("bp_cnt", 64'(stall_cnt), 64'd4);
      out_ready = 1'b1;
      tick();
      check("bp_b",       64'(out_data), 64'hB);
      check("bp_rdy_up",  64'(in_ready), 64'd1);
      tick();
      check("bp_c", 64'(out_data), 64'hC);
      in_data = 32'hD; in_ctrl = 16'h00D;
      tick();
      check("bp_d", 64'(out_data), 64'hD);
      check("bp_d_ctrl", 64'(out_ctrl), 64'h00D);
      in_valid = 1'b0;
      tick();
      check("bp_drained", 64'(out_valid), 64'd0);
      check("bp_cnt_end", 64'(stall_cnt), 64'd4);

      // Flush with both entries full
      in_valid = 1'b1; out_ready = 1'b0;
      in_data = 32'h11; in_ctrl = 16'h1111;
      tick();
      in_data = 32'h22; in_ctrl = 16'h2222;
      tick();
      check("fl_full", 64'(in_ready), 64'd0);
      in_data = 32'hEE; in_ctrl = 16'hEEEE;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_vld",  64'(out_valid), 64'd0);
      check("fl_ctrl", 64'(out_ctrl), 64'd0);
      check("fl_rdy",  64'(in_ready), 64'd1);
      check("fl_cnt",  64'(stall_cnt), 64'd5);
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      check("fl_no_e", 64'(out_valid), 64'd0);

      // Flush discarding a beat accepted in the same cycle
      in_valid = 1'b1; in_data = 32'h33; in_ctrl = 16'h3333;
      tick();
      check("fl2_load", 64'(out_data), 64'h33);
      in_data = 32'hE1; in_ctrl = 16'hE1E1;
      flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("fl2_vld", 64'(out_valid), 64'd0);
      tick();
      check("fl2_no_e", 64'(out_valid), 64'd0);

      // Bubble control masking
      in_valid = 1'b1; in_data = 32'h5A; in_ctrl = 16'hFFFF;
      tick();
      check("bub_ctrl_on", 64'(out_ctrl), 64'hFFFF);
      in_valid = 1'b0;
      tick();
      check("bub_vld",      64'(out_valid), 64'd0);
      check("bub_ctrl_off", 64'(out_ctrl), 64'h0);
      check("bub_data",     64'(out_data), 64'h5A);

      // Stall counter saturation and clear
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("cnt_clr", 64'(stall_cnt), 64'd0);
      in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check("cnt_sat", 64'(stall_cnt), 64'd15);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("cnt_clr_stall", 64'(stall_cnt), 64'd0);
      tick();
      check("cnt_resume", 64'(stall_cnt), 64'd1);

      // Asynchronous reset mid-cycle with both entries full
      in_valid = 1'b1; in_data = 32'h82;
      tick();
      in_valid = 1'b0;
      check("ar_full", 64'(in_ready), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_vld",  64'(out_valid), 64'd0);
      check("ar_ctrl", 64'(out_ctrl), 64'd0);
      check("ar_data", 64'(out_data), 64'd0);
      check("ar_rdy",  64'(in_ready), 64'd1);
      check("ar_cnt",  64'(stall_cnt), 64'd0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      check("ar_post_vld", 64'(out_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, handshaked pipeline-stage register that supersedes the fixed-field, single-enable stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque data bundle plus a control bundle between two stages using a valid/ready handshake. A two-entry skid buffer keeps the upstream ready signal registered while still sustaining one transfer per cycle. It adds a synchronous flush that turns in-flight entries into bubbles, zeroes control on bubbles so downstream stages see NOPs, and keeps a saturating stall counter for performance debug.

## Interface
- DATA_W, 128, width of the datapath bundle (for example pc4, alu result, rs/rt values); passed through unchanged and never zeroed except at reset.
- CTRL_W, 16, width of the control bundle (for example DMEM/RF enables, selects, waddr); forced to 0 whenever the output is not valid.
- CNT_W, 16, width of the stall counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers a beat.
- in_ready  out  1  stage can accept a beat; equals !skid_valid (a registered term only).
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  main entry holds a valid beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  DATA_W  main-entry datapath bundle.
- out_ctrl  out  CTRL_W  main-entry control bundle; 0 when out_valid=0.
- flush  in  1  synchronous kill of all held and incoming beats.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  number of cycles with out_valid & !out_ready.

## Operation
- Storage is two entries: main (drives the outputs) and skid. Each entry holds a valid bit, data and ctrl.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority order: reset, then flush, then normal update.
- Normal update, evaluated each clock:
  - Skid valid and out_fire: skid moves to main; skid becomes empty. in_ready was 0, so no input is accepted this cycle.
  - Skid valid and !out_fire: hold both entries.
  - Skid empty and in_fire, with main empty or out_fire: the beat loads main.
  - Skid empty and in_fire, with main valid and !out_fire: the beat loads skid.
  - Skid empty, !in_fire, out_fire: main becomes empty.
- Flush: main_valid and skid_valid clear at the next edge.
  - A beat with in_fire in the same cycle is consumed and discarded.
  - out_fire in the flush cycle is still a legal transfer; downstream owns that beat.
  - in_ready is 1 in the cycle after a flush.
- Bubble masking: out_ctrl = main_valid ? main_ctrl : 0. out_data keeps its last value when invalid.
- Stall counter:
  - Increments by 1 when out_valid & !out_ready and !flush, saturating at 2^CNT_W-1.
  - cnt_clr has priority over increment; the counter reads 0 next cycle.
- Ordering is strictly FIFO; there is no reordering and no duplication.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ctrl=0, skid cleared, in_ready=1, stall_cnt=0. Inputs are ignored while in reset. Deassertion takes effect at the first clk edge after rst_n rises.
- Latency: 1 cycle from in_fire to out_valid when main is empty or draining.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- out_ready low for N cycles with in_valid held high:
  - The first held beat stays in main.
  - The next beat goes to skid.
  - in_ready drops 1 cycle after the skid fills.
  - stall_cnt rises by N.
- After out_ready returns high: the skid drains to main, and in_ready rises the following cycle.
- Handshake rules: out_valid and out_data/out_ctrl are stable while out_valid & !out_ready. No combinational path from out_ready to in_ready.
- Reset asserted mid-transfer: all entries are lost immediately, with no partial update.

## Test plan
- Reset: drive rst_n=0 asynchronously mid-cycle with both entries full -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, stall_cnt=0 before the next edge.
- Streaming: in_valid=1, out_ready=1, in_data=0..9 on consecutive cycles -> out_data 0..9 one cycle later, no gaps, in_ready always 1.
- Backpressure: stream A,B,C,D with out_ready=0 for cycles 2-5 -> main=A, skid=B, in_ready=0 from cycle 3, stall_cnt=4. On release, output order is A,B,C,D with no loss or duplication.
- Flush: both entries full, in_valid=1 with beat E, flush=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1. E never appears at the output.
- Bubble control: in_ctrl=0xFFFF, then in_valid=0 -> out_ctrl=0xFFFF for one cycle, then 0x0000 while out_data retains its value.
- Counter: CNT_W=4, hold a stall for 20 cycles -> stall_cnt saturates at 15. cnt_clr=1 together with a stall -> 0 next cycle.
